// File: rtl/l2_mem_responder_pkg.sv
// +----------------------------------------------------------------------------+
// | RVS192_package : shared types for the L2 memory-side responder             |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package RVS192_package;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } resp_state_t;

  typedef enum logic {
    OP_DIRTY   = 1'b0,
    OP_REPLACE = 1'b1
  } resp_op_t;

  localparam logic CLIENT_INST = 1'b0;
  localparam logic CLIENT_DATA = 1'b1;

endpackage

`default_nettype wire

// File: rtl/l2_mem_responder_if.sv
// +----------------------------------------------------------------------------+
// | l2_mem_responder_if : request/done, L2 line-buffer and memory beat signals |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface l2_mem_responder_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_BEATS = 4
);
  localparam int BEAT_W = $clog2(LINE_BEATS);

  logic              inst_mem_dirty_req;
  logic              inst_mem_replace_req;
  logic              data_mem_dirty_req;
  logic              data_mem_replace_req;
  logic [ADDR_W-1:0] inst_dirty_addr;
  logic [ADDR_W-1:0] inst_replace_addr;
  logic [ADDR_W-1:0] data_dirty_addr;
  logic [ADDR_W-1:0] data_replace_addr;
  logic              inst_mem_dirty_done;
  logic              inst_mem_replace_done;
  logic              data_mem_dirty_done;
  logic              data_mem_replace_done;

  logic              l2_rd_sel;
  logic [BEAT_W-1:0] l2_rd_beat;
  logic [DATA_W-1:0] l2_rd_data;
  logic              l2_wr_en;
  logic              l2_wr_sel;
  logic [BEAT_W-1:0] l2_wr_beat;
  logic [DATA_W-1:0] l2_wr_data;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // Responder view.
  modport slave (
    input  inst_mem_dirty_req, inst_mem_replace_req,
           data_mem_dirty_req, data_mem_replace_req,
           inst_dirty_addr, inst_replace_addr, data_dirty_addr, data_replace_addr,
           l2_rd_data, mem_ack, mem_rdata,
    output inst_mem_dirty_done, inst_mem_replace_done,
           data_mem_dirty_done, data_mem_replace_done,
           l2_rd_sel, l2_rd_beat, l2_wr_en, l2_wr_sel, l2_wr_beat, l2_wr_data,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  // L2 controller / memory bridge view.
  modport master (
    output inst_mem_dirty_req, inst_mem_replace_req,
           data_mem_dirty_req, data_mem_replace_req,
           inst_dirty_addr, inst_replace_addr, data_dirty_addr, data_replace_addr,
           l2_rd_data, mem_ack, mem_rdata,
    input  inst_mem_dirty_done, inst_mem_replace_done,
           data_mem_dirty_done, data_mem_replace_done,
           l2_rd_sel, l2_rd_beat, l2_wr_en, l2_wr_sel, l2_wr_beat, l2_wr_data,
           mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/l2_mem_responder_arb.sv
// +----------------------------------------------------------------------------+
// | l2_mem_resp_arb : pending-vector to grant encoder (dirty before replace)   |
// | Option macro: L2_MEM_RESP_RR_ARB_EN (round-robin between clients)          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module l2_mem_resp_arb
  import RVS192_package::*;
(
  // bit index = {client, op}: 0 inst dirty, 1 inst replace, 2 data dirty, 3 data replace
  input  wire logic [3:0] i_pend,
`ifdef L2_MEM_RESP_RR_ARB_EN
  input  wire logic       i_last,
`endif
  output logic            o_vld,
  output logic            o_client,
  output resp_op_t        o_op
);

  logic w_inst_any;
  logic w_data_any;
  logic w_pick;
  logic w_dirty;

  always_comb begin
    w_inst_any = |i_pend[1:0];
    w_data_any = |i_pend[3:2];
`ifdef L2_MEM_RESP_RR_ARB_EN
    // Contention goes to whichever client was not served last.
    if (w_inst_any && w_data_any) begin
      w_pick = ~i_last;
    end else begin
      w_pick = w_data_any ? CLIENT_DATA : CLIENT_INST;
    end
`else
    w_pick = w_data_any ? CLIENT_DATA : CLIENT_INST;
`endif
    w_dirty  = w_pick ? i_pend[2] : i_pend[0];
    o_vld    = w_inst_any | w_data_any;
    o_client = w_pick;
    o_op     = w_dirty ? OP_DIRTY : OP_REPLACE;
  end

endmodule

`default_nettype wire

// File: rtl/l2_mem_responder.sv
// +----------------------------------------------------------------------------+
// | l2_mem_responder : line-burst memory responder for L2 miss handling        |
// | Option macro: L2_MEM_RESP_RR_ARB_EN (round-robin client arbitration)       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module l2_mem_responder
  import RVS192_package::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_BEATS = 4
) (
  input  wire logic         clk_l2,
  input  wire logic         rst,
  l2_mem_responder_if.slave bus
);

  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam int OFF    = BEAT_W + 2;

  resp_state_t              r_state;
  logic [3:0]               r_req_q;
  logic [3:0]               r_pend;
  logic [3:0]               r_done;
  logic                     r_prime;
  logic                     r_client;
  resp_op_t                 r_op;
  logic [ADDR_W-OFF-1:0]    r_base;
  logic [BEAT_W-1:0]        r_beat;
`ifdef L2_MEM_RESP_RR_ARB_EN
  logic                     r_last;
`endif

  logic [3:0]               w_req;
  logic [3:0]               w_rise;
  logic                     w_gnt_vld;
  logic                     w_gnt_client;
  resp_op_t                 w_gnt_op;
  logic [1:0]               w_gnt_idx;
  logic [1:0]               w_cur_idx;
  logic [ADDR_W-1:0]        w_sel_addr;
  logic                     w_unused;
  logic                     w_xfer;
  logic                     w_dirty;
  logic                     w_repl;
  logic                     w_wr_en;
  logic [DATA_W-1:0]        w_rdata;

  assign w_req = {bus.data_mem_replace_req, bus.data_mem_dirty_req,
                  bus.inst_mem_replace_req, bus.inst_mem_dirty_req};

  // r_prime masks the first post-reset edge so a level held across reset must re-rise.
  assign w_rise = w_req & ~r_req_q & {4{r_prime}};

  l2_mem_resp_arb u_arb (
    .i_pend   (r_pend),
`ifdef L2_MEM_RESP_RR_ARB_EN
    .i_last   (r_last),
`endif
    .o_vld    (w_gnt_vld),
    .o_client (w_gnt_client),
    .o_op     (w_gnt_op)
  );

  assign w_gnt_idx = {w_gnt_client, (w_gnt_op == OP_REPLACE)};
  assign w_cur_idx = {r_client, (r_op == OP_REPLACE)};

  always_comb begin
    case (w_gnt_idx)
      2'd0:    w_sel_addr = bus.inst_dirty_addr;
      2'd1:    w_sel_addr = bus.inst_replace_addr;
      2'd2:    w_sel_addr = bus.data_dirty_addr;
      default: w_sel_addr = bus.data_replace_addr;
    endcase
  end

  // Line-offset bits of the base are don't-care; the beat counter supplies them.
  assign w_unused = ^w_sel_addr[OFF-1:0];

  always_ff @(posedge clk_l2 or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_req_q  <= '0;
      r_pend   <= '0;
      r_done   <= '0;
      r_prime  <= 1'b0;
      r_client <= CLIENT_INST;
      r_op     <= OP_DIRTY;
      r_base   <= '0;
      r_beat   <= '0;
`ifdef L2_MEM_RESP_RR_ARB_EN
      r_last   <= CLIENT_INST;
`endif
    end else begin
      r_prime <= 1'b1;
      r_req_q <= w_req;
      // A new edge in the done cycle re-arms the request.
      r_pend  <= (r_pend & ~r_done) | w_rise;
      r_done  <= '0;
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_state  <= XFER;
            r_client <= w_gnt_client;
            r_op     <= w_gnt_op;
            r_base   <= w_sel_addr[ADDR_W-1:OFF];
            r_beat   <= '0;
          end
        end
        XFER: begin
          if (bus.mem_ack) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == BEAT_W'(LINE_BEATS - 1)) begin
              r_state           <= DONE;
              r_done[w_cur_idx] <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
`ifdef L2_MEM_RESP_RR_ARB_EN
          r_last  <= ~r_last;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_xfer  = (r_state == XFER);
  assign w_dirty = w_xfer && (r_op == OP_DIRTY);
  assign w_repl  = w_xfer && (r_op == OP_REPLACE);
  assign w_wr_en = w_repl && bus.mem_ack;
  assign w_rdata = bus.mem_rdata;

  assign bus.mem_req    = w_xfer;
  assign bus.mem_we     = w_dirty;
  assign bus.mem_addr   = w_xfer ? {r_base, r_beat, 2'b00} : '0;
  assign bus.mem_wdata  = bus.l2_rd_data;

  assign bus.l2_rd_sel  = w_dirty & r_client;
  assign bus.l2_rd_beat = w_dirty ? r_beat : '0;

  assign bus.l2_wr_en   = w_wr_en;
  assign bus.l2_wr_sel  = w_repl & r_client;
  assign bus.l2_wr_beat = w_repl ? r_beat : '0;
  assign bus.l2_wr_data = w_wr_en ? w_rdata : '0;

  assign bus.inst_mem_dirty_done   = r_done[0];
  assign bus.inst_mem_replace_done = r_done[1];
  assign bus.data_mem_dirty_done   = r_done[2];
  assign bus.data_mem_replace_done = r_done[3];

endmodule

`default_nettype wire

// File: tb/tb_l2_mem_responder.sv
// +----------------------------------------------------------------------------+
// | tb_l2_mem_responder : self-checking bench for l2_mem_responder             |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_l2_mem_responder;

  localparam int LB = 4;

  typedef struct packed {
    logic [1:0]  kind;   // 0 memory beat, 1 L2 refill write, 2 done pulse
    logic [3:0]  tag;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  l2_mem_responder_if #(.ADDR_W(32), .DATA_W(32), .LINE_BEATS(LB)) bus ();

  l2_mem_responder #(.ADDR_W(32), .DATA_W(32), .LINE_BEATS(LB)) dut (
    .clk_l2 (clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          n_done = 0;
  int          n_wr  = 0;
  int          gap_fix = 0;
  bit          gap_rand = 1'b0;
  bit          stray_en = 1'b0;
  logic [31:0] m_salt = 32'h0;
  logic [31:0] rd_salt = 32'h0;
  logic        m_last = 1'b0;
  logic [31:0] a_req [4];
  ev_t         q_log[$];
  ev_t         e_log[$];
  int          q_beat_cyc[$];
  int          q_done_cyc[$];

  // L2 line buffer and request addresses presented by the controller side.
  always_comb begin
    bus.l2_rd_data        = (bus.l2_rd_sel ? 32'hDA7A_0000 : 32'h1A57_0000)
                            + 32'(bus.l2_rd_beat) * 32'd17 + rd_salt;
    bus.inst_dirty_addr   = a_req[0];
    bus.inst_replace_addr = a_req[1];
    bus.data_dirty_addr   = a_req[2];
    bus.data_replace_addr = a_req[3];
  end

  // Memory bridge model plus event monitor.
  initial begin : mem_side
    int   wait_cnt;
    int   cur_gap;
    ev_t  mev;
    logic [3:0] dn;
    wait_cnt = 0;
    cur_gap  = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (bus.mem_req) begin
        if (wait_cnt >= cur_gap) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = (bus.mem_addr >> 2) + m_salt;
          wait_cnt      = 0;
          cur_gap       = gap_rand ? int'($urandom_range(0, 2)) : gap_fix;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom;
          wait_cnt++;
        end
      end else begin
        bus.mem_ack   = stray_en && ($urandom_range(0, 3) == 0);
        bus.mem_rdata = $urandom;
        wait_cnt      = 0;
        cur_gap       = gap_rand ? int'($urandom_range(0, 2)) : gap_fix;
      end
      @(negedge clk);
      if (bus.mem_req && bus.mem_ack) begin
        mev.kind = 2'd0;
        mev.tag  = {3'b000, bus.mem_we};
        mev.a    = bus.mem_addr;
        mev.d    = bus.mem_we ? bus.mem_wdata : 32'h0;
        q_log.push_back(mev);
        q_beat_cyc.push_back(cyc);
      end
      if (bus.l2_wr_en) begin
        mev.kind = 2'd1;
        mev.tag  = {1'b0, bus.l2_wr_sel, bus.l2_wr_beat};
        mev.a    = 32'h0;
        mev.d    = bus.l2_wr_data;
        q_log.push_back(mev);
        n_wr++;
      end
      dn = {bus.data_mem_replace_done, bus.data_mem_dirty_done,
            bus.inst_mem_replace_done, bus.inst_mem_dirty_done};
      for (int b = 0; b < 4; b++) begin
        if (dn[b]) begin
          mev.kind = 2'd2;
          mev.tag  = 4'(b);
          mev.a    = 32'h0;
          mev.d    = 32'h0;
          q_log.push_back(mev);
          q_done_cyc.push_back(cyc);
          n_done++;
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] l2word(input logic sel, input int beat);
    return (sel ? 32'hDA7A_0000 : 32'h1A57_0000) + 32'(beat) * 32'd17 + rd_salt;
  endfunction

  // One line burst for request idx = {client, op}.
  task automatic model_service(input logic [1:0] idx);
    ev_t         ev;
    logic        cl;
    logic        repl;
    logic [31:0] base;
    logic [31:0] ba;
    cl   = idx[1];
    repl = idx[0];
    base = a_req[idx] & ~32'(LB * 4 - 1);
    for (int i = 0; i < LB; i++) begin
      ba      = base + 32'(4 * i);
      ev.kind = 2'd0;
      ev.tag  = {3'b000, ~repl};
      ev.a    = ba;
      ev.d    = repl ? 32'h0 : l2word(cl, i);
      e_log.push_back(ev);
      if (repl) begin
        ev.kind = 2'd1;
        ev.tag  = {1'b0, cl, 2'(i)};
        ev.a    = 32'h0;
        ev.d    = (ba >> 2) + m_salt;
        e_log.push_back(ev);
      end
    end
    ev.kind = 2'd2;
    ev.tag  = {2'b00, idx};
    ev.a    = 32'h0;
    ev.d    = 32'h0;
    e_log.push_back(ev);
    m_last = ~m_last;
  endtask

  // Service order for a set of requests that become pending together.
  task automatic model_arb(input logic [3:0] mask);
    logic [3:0] m;
    logic       cl;
    logic [1:0] idx;
    m = mask;
    while (m != 4'b0) begin
      if ((|m[3:2]) && (|m[1:0])) begin
`ifdef L2_MEM_RESP_RR_ARB_EN
        cl = ~m_last;
`else
        cl = 1'b1;
`endif
      end else begin
        cl = |m[3:2];
      end
      idx    = m[{cl, 1'b0}] ? {cl, 1'b0} : {cl, 1'b1};
      m[idx] = 1'b0;
      model_service(idx);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_req(input logic [3:0] v);
    bus.inst_mem_dirty_req   = v[0];
    bus.inst_mem_replace_req = v[1];
    bus.data_mem_dirty_req   = v[2];
    bus.data_mem_replace_req = v[3];
  endtask

  task automatic pulse_req(input logic [3:0] v, output int t_edge);
    @(posedge clk); #1;
    drive_req(v);
    t_edge = cyc;
    @(posedge clk); #1;
    drive_req(4'b0);
  endtask

  task automatic clear_logs();
    q_log.delete();
    e_log.delete();
    q_beat_cyc.delete();
    q_done_cyc.delete();
    n_done = 0;
    n_wr   = 0;
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int k = 0; k < budget && n_done < n; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int t;
    stray_en = 1'b1;
    a_req[0] = 32'h0000_2200;
    drive_req(4'b0001);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.l2_wr_en,
         bus.inst_mem_dirty_done, bus.inst_mem_replace_done,
         bus.data_mem_dirty_done, bus.data_mem_replace_done,
         bus.l2_rd_sel, bus.l2_rd_beat, bus.l2_wr_sel, bus.l2_wr_beat,
         bus.l2_wr_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wr_en=%b rd_beat=%0d",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.l2_wr_en, bus.l2_rd_beat);
    end
    rst = 1'b0;
    m_last = 1'b0;
    clear_logs();
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (q_log.size() != 0) begin
      bad++;
      $display("FAIL reset_held_level: got %0d events want 0", q_log.size());
    end
    drive_req(4'b0);
    repeat (2) @(posedge clk);
    model_arb(4'b0001);
    pulse_req(4'b0001, t);
    wait_done(1, 100);
    total++;
    if (q_log.size() != e_log.size()) begin
      bad++;
      $display("FAIL reset_rerise size: got %0d want %0d", q_log.size(), e_log.size());
    end
    foreach (e_log[i]) if (i < q_log.size()) begin
      total++;
      if (q_log[i] !== e_log[i]) begin
        bad++;
        $display("FAIL reset_rerise ev%0d: got %h want %h", i, q_log[i], e_log[i]);
      end
    end
    stray_en = 1'b0;
  endtask

  task automatic test_dirty_latency();
    int t;
    clear_logs();
    gap_fix  = 0;
    rd_salt  = 32'h0000_0500;
    a_req[2] = 32'h0000_1234;
    model_arb(4'b0100);
    pulse_req(4'b0100, t);
    wait_done(1, 100);
    total++;
    if (q_beat_cyc.size() < 1 || q_beat_cyc[0] != t + 2) begin
      bad++;
      $display("FAIL dirty_first_req_cycle: got %0d want %0d",
               (q_beat_cyc.size() > 0) ? q_beat_cyc[0] - t : -1, 2);
    end
    total++;
    if (q_done_cyc.size() != 1 || q_done_cyc[0] != t + 2 + LB) begin
      bad++;
      $display("FAIL dirty_done_cycle: got %0d pulses first at +%0d want 1 at +%0d",
               q_done_cyc.size(), (q_done_cyc.size() > 0) ? q_done_cyc[0] - t : -1, 2 + LB);
    end
    total++;
    if (q_log.size() != e_log.size()) begin
      bad++;
      $display("FAIL dirty_burst size: got %0d want %0d", q_log.size(), e_log.size());
    end
    foreach (e_log[i]) if (i < q_log.size()) begin
      total++;
      if (q_log[i] !== e_log[i]) begin
        bad++;
        $display("FAIL dirty_burst ev%0d: got %h want %h", i, q_log[i], e_log[i]);
      end
    end
  endtask

  task automatic test_refill_gaps();
    int t;
    clear_logs();
    gap_fix  = 2;
    m_salt   = 32'h0000_0090;
    a_req[1] = 32'h0000_0040;
    model_arb(4'b0010);
    pulse_req(4'b0010, t);
    wait_done(1, 200);
    total++;
    if (n_wr != LB) begin
      bad++;
      $display("FAIL refill_wr_count: got %0d want %0d", n_wr, LB);
    end
    total++;
    if (q_log.size() != e_log.size()) begin
      bad++;
      $display("FAIL refill size: got %0d want %0d", q_log.size(), e_log.size());
    end
    foreach (e_log[i]) if (i < q_log.size()) begin
      total++;
      if (q_log[i] !== e_log[i]) begin
        bad++;
        $display("FAIL refill ev%0d: got %h want %h", i, q_log[i], e_log[i]);
      end
    end
    gap_fix = 0;
  endtask

  task automatic test_all_four();
    int t;
    clear_logs();
    a_req[0] = 32'h1000_0010;
    a_req[1] = 32'h2000_0020;
    a_req[2] = 32'h3000_0030;
    a_req[3] = 32'h4000_0040;
    m_salt   = 32'h1111_0000;
    model_arb(4'b1111);
    pulse_req(4'b1111, t);
    wait_done(4, 300);
    total++;
    if (q_log.size() != e_log.size()) begin
      bad++;
      $display("FAIL all_four size: got %0d want %0d", q_log.size(), e_log.size());
    end
    foreach (e_log[i]) if (i < q_log.size()) begin
      total++;
      if (q_log[i] !== e_log[i]) begin
        bad++;
        $display("FAIL all_four ev%0d: got %h want %h", i, q_log[i], e_log[i]);
      end
    end
  endtask

  task automatic test_held_level();
    clear_logs();
    a_req[2] = 32'h0000_8884;
    model_arb(4'b0100);
    @(posedge clk); #1;
    drive_req(4'b0100);
    repeat (20) @(posedge clk);
    #1;
    drive_req(4'b0000);
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (n_done != 1) begin
      bad++;
      $display("FAIL held_level done_count: got %0d want 1", n_done);
    end
    foreach (e_log[i]) if (i < q_log.size()) begin
      total++;
      if (q_log[i] !== e_log[i]) begin
        bad++;
        $display("FAIL held_level ev%0d: got %h want %h", i, q_log[i], e_log[i]);
      end
    end
  endtask

  task automatic test_reset_midburst();
    int t;
    clear_logs();
    a_req[3] = 32'h0000_0C00;
    m_salt   = 32'h0000_7700;
    pulse_req(4'b1000, t);
    for (int k = 0; k < 50 && n_wr < 2; k++) @(negedge clk);
    @(posedge clk); #2;
    total++;
    if (bus.l2_wr_en !== 1'b1) begin
      bad++;
      $display("FAIL midburst_pre_wr_en: got %b want 1", bus.l2_wr_en);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (bus.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL midburst_mem_req_drop: got %b want 0", bus.mem_req);
    end
    total++;
    if (bus.l2_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL midburst_wr_en_drop: got %b want 0", bus.l2_wr_en);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_last = 1'b0;
    clear_logs();
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (q_log.size() != 0) begin
      bad++;
      $display("FAIL midburst_no_done: got %0d events want 0", q_log.size());
    end
    model_arb(4'b1000);
    pulse_req(4'b1000, t);
    wait_done(1, 100);
    total++;
    if (q_log.size() != e_log.size()) begin
      bad++;
      $display("FAIL midburst_restart size: got %0d want %0d", q_log.size(), e_log.size());
    end
    foreach (e_log[i]) if (i < q_log.size()) begin
      total++;
      if (q_log[i] !== e_log[i]) begin
        bad++;
        $display("FAIL midburst_restart ev%0d: got %h want %h", i, q_log[i], e_log[i]);
      end
    end
  endtask

  task automatic test_retrigger();
    int t;
    clear_logs();
    gap_fix  = 0;
    a_req[2] = 32'h0000_5550;
    model_arb(4'b0100);
    model_arb(4'b0100);
    pulse_req(4'b0100, t);
    repeat (LB + 1) @(posedge clk);
    #1;
    drive_req(4'b0100);
    total++;
    if (bus.data_mem_dirty_done !== 1'b1) begin
      bad++;
      $display("FAIL retrigger_done_cycle: got %b want 1", bus.data_mem_dirty_done);
    end
    @(posedge clk); #1;
    drive_req(4'b0000);
    wait_done(2, 100);
    total++;
    if (q_log.size() != e_log.size()) begin
      bad++;
      $display("FAIL retrigger size: got %0d want %0d", q_log.size(), e_log.size());
    end
    foreach (e_log[i]) if (i < q_log.size()) begin
      total++;
      if (q_log[i] !== e_log[i]) begin
        bad++;
        $display("FAIL retrigger ev%0d: got %h want %h", i, q_log[i], e_log[i]);
      end
    end
  endtask

  task automatic test_random();
    int         t;
    logic [3:0] mask;
    gap_rand = 1'b1;
    stray_en = 1'b1;
    for (int r = 0; r < 25; r++) begin
      clear_logs();
      mask    = 4'($urandom_range(1, 15));
      m_salt  = $urandom;
      rd_salt = $urandom;
      for (int k = 0; k < 4; k++) a_req[k] = $urandom;
      model_arb(mask);
      pulse_req(mask, t);
      wait_done($countones(mask), 400);
      total++;
      if (q_log.size() != e_log.size()) begin
        bad++;
        $display("FAIL random r%0d mask=%b size: got %0d want %0d",
                 r, mask, q_log.size(), e_log.size());
      end
      foreach (e_log[i]) if (i < q_log.size()) begin
        total++;
        if (q_log[i] !== e_log[i]) begin
          bad++;
          $display("FAIL random r%0d ev%0d: got %h want %h", r, i, q_log[i], e_log[i]);
        end
      end
    end
    gap_rand = 1'b0;
    stray_en = 1'b0;
  endtask

  initial begin
    drive_req(4'b0);
    for (int k = 0; k < 4; k++) a_req[k] = 32'h0;
    test_reset();
    test_dirty_latency();
    test_refill_gaps();
    test_all_four();
    test_held_level();
    test_reset_midburst();
    test_retrigger();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/l2_mem_responder.md
Name: l2_mem_responder

Overview:
- Memory-side responder for the L2 cache controller's miss-handling handshake.
- Services four request lines: inst/data × dirty-writeback/replace-refill.
- Runs one line-sized burst per request on a simple per-beat req/ack memory port, then returns a one-cycle done pulse.
- Sits between the L2 controller/data array and the external memory bridge, entirely in the clk_l2 domain.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, memory beat width
- LINE_BEATS, 4, beats per L2 line (power of two, ≥2)

Ports:
- clk_l2  in  1  L2 clock
- rst  in  1  asynchronous, active-high reset
- inst_mem_dirty_req, inst_mem_replace_req, data_mem_dirty_req, data_mem_replace_req  in  1 each  requests (level or one-cycle pulse)
- inst_dirty_addr, inst_replace_addr, data_dirty_addr, data_replace_addr  in  ADDR_W each  line base addresses, stable from request until done
- inst_mem_dirty_done, inst_mem_replace_done, data_mem_dirty_done, data_mem_replace_done  out  1 each  completion pulses
- l2_rd_sel  out  1  writeback source: 0=inst, 1=data
- l2_rd_beat  out  log2(LINE_BEATS)  writeback beat index
- l2_rd_data  in  DATA_W  L2 line-buffer word; combinational from l2_rd_sel/l2_rd_beat
- l2_wr_en  out  1  refill word write strobe
- l2_wr_sel  out  1  refill target: 0=inst, 1=data
- l2_wr_beat  out  log2(LINE_BEATS)  refill beat index
- l2_wr_data  out  DATA_W  refill word
- mem_req  out  1  beat request
- mem_we  out  1  1=write (dirty), 0=read (replace)
- mem_addr  out  ADDR_W  beat byte address
- mem_wdata  out  DATA_W  write data (= l2_rd_data)
- mem_ack  in  1  beat accepted/complete
- mem_rdata  in  DATA_W  read data, valid with mem_ack

Behaviour:
- Request capture
  - Each request line has a registered copy; a rising edge (req & !req_q) sets its pending bit.
  - A held level does not re-trigger.
  - Pending is cleared in the cycle its done pulses.
  - If a new rising edge coincides with the clear, set wins and the request is serviced again.
- Arbitration (IDLE only)
  - Data before inst.
  - Within a client, dirty before replace (writeback must precede refill).
  - The selection (client, op) and the line base address are registered on grant.
- FSM states: IDLE, XFER, DONE.
  - IDLE → XFER when any pending bit is set; beat counter cleared.
  - XFER:
    - mem_req=1; mem_we=1 for dirty, 0 for replace.
    - mem_addr = {base[ADDR_W-1:OFF], beat, 2'b00}, where OFF = log2(LINE_BEATS)+2; the base's low OFF bits are ignored.
    - Dirty: l2_rd_sel = client, l2_rd_beat = beat, mem_wdata = l2_rd_data.
    - Replace: on mem_ack, l2_wr_en=1 (combinational with mem_ack), l2_wr_data = mem_rdata, l2_wr_beat = beat, l2_wr_sel = client.
    - Each mem_ack increments beat.
    - mem_ack on beat LINE_BEATS-1 → DONE.
    - mem_req remains high between beats; no ack means wait indefinitely.
  - DONE: the matching *_done output is 1 for exactly one cycle; pending bit cleared; → IDLE. Next grant is earliest in the following cycle.
- Latency: a request edge at cycle t gives pending at t+1 and mem_req at t+2; with zero-wait ack, done asserts at t+2+LINE_BEATS.
- Reset (at any time, including mid-burst): the following clear immediately:
  - FSM to IDLE, beat=0, pending=0, req_q=0.
  - All outputs 0: mem_req, mem_we, mem_addr, l2_wr_en, all done, l2_rd_sel, l2_rd_beat, l2_wr_*.
  - After reset, a request already held high is not captured until it re-rises.
- mem_ack outside XFER is ignored.

Optional Feature:
- Macro: L2_MEM_RESP_RR_ARB_EN.
- Defined: client arbitration is round-robin. A 1-bit last-client register flips after each DONE; the other client wins when both are pending. Dirty-before-replace still holds within a client. The register resets to inst, so data is favoured first.
- Undefined: fixed data-over-inst priority as above.

Decomposition:
- RVS192_package holds:
  - enum resp_state_t {IDLE, XFER, DONE}
  - enum resp_op_t {OP_DIRTY, OP_REPLACE}
  - constants CLIENT_INST=0, CLIENT_DATA=1
- One sub-module: l2_mem_resp_arb, a combinational pending-vector-to-grant encoder that contains the RR option.
- The FSM, counters and datapath stay in the top module.

Test Plan:
- Data dirty pulse, data_dirty_addr=0x0000_1234, zero-wait ack → mem_we=1, addresses 0x1230/0x1234/0x1238/0x123C; data_mem_dirty_done pulses once, 6 cycles after the req edge.
- Inst replace, addr 0x0000_0040, mem_rdata 0xA0..0xA3 with 2-cycle ack gaps → l2_wr_en 4 times, beats 0..3, data 0xA0..0xA3, l2_wr_sel=0, then inst_mem_replace_done.
- All four requests raised in one cycle → service order data-dirty, data-replace, inst-dirty, inst-replace; four single done pulses. With L2_MEM_RESP_RR_ARB_EN: data-dirty, inst-dirty, data-replace, inst-replace.
- Dirty req held high 20 cycles and kept high 1 cycle past done → exactly one burst, no retrigger.
- rst asserted after beat 1 ack of a refill → mem_req and l2_wr_en drop immediately; no done pulse; a fresh req edge after release restarts at beat 0.
- Req edge coinciding with its own DONE cycle → a second full burst follows.
